fetch_sequencer: RTL and testbench

Two-byte instruction fetch stage that sits directly upstream of the decode/execute control logic in Control_Unit_Combined_With_ALU_System. It drives the fetch subset of the ALU_System control word: PC select and increment, the memory read, and the IR low/high load. The 16-bit instruction is assembled in IR, and the block presents it downstream with a valid/ready handshake. It also supports flush (branch redirect) and HALT-opcode detection.

---
 rtl/fetch_sequencer_pkg.sv | 44 ++++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch/decode constants and the ALU_System fetch control word.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Encodings must track the ALU_System decode; the decode stage imports these too.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        VALID    = 3'd3,
        HALT     = 3'd4
    } fetch_state_e;

    localparam logic [1:0] PC_SEL      = 2'b00;
    localparam logic [3:0] PC_RSEL     = 4'b0111;
    localparam logic [1:0] ARF_FUN_INC = 2'b01;
    localparam logic [1:0] IR_FUN_LOAD = 2'b10;

    typedef struct packed {
        logic [1:0] out_d_sel;
        logic [1:0] arf_fun;
        logic [3:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_en;
        logic [1:0] ir_fun;
        logic       mem_wr;
        logic       mem_cs;
    } fetch_ctrl_t;

    // Inactive word keeps PC selected with INC function but every register disabled.
    function automatic fetch_ctrl_t ctrl_word(input logic active, input logic hi_byte);
        fetch_ctrl_t c;
        c.out_d_sel   = PC_SEL;
        c.arf_fun     = ARF_FUN_INC;
        c.arf_reg_sel = active ? PC_RSEL : 4'b1111;
        c.ir_lh       = active & hi_byte;
        c.ir_en       = active;
        c.ir_fun      = IR_FUN_LOAD;
        c.mem_wr      = 1'b0;
        c.mem_cs      = ~active;
        return c;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch into IR with valid/ready hand-off to decode, flush and HALT stop.
// Latency: 2 cycles from leaving IDLE to Instr_Valid; 3 cycles/instruction back-to-back.
// Backpressure: holds Instr_Valid in VALID until Instr_Ready; no new fetch starts meanwhile.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          COUNT_W     = 8,
    parameter bit          HALT_EN     = 1'b1,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Flush,
    input  logic               Instr_Ready,
    input  logic [15:0]        IROut,
    output logic [1:0]         ARF_OutDSel,
    output logic [1:0]         ARF_FunSel,
    output logic [3:0]         ARF_RegSel,
    output logic               IR_LH,
    output logic               IR_Enable,
    output logic [1:0]         IR_Funsel,
    output logic               Mem_WR,
    output logic               Mem_CS,
    output logic               Instr_Valid,
    output logic               Halted,
    output logic               Busy,
    output logic [COUNT_W-1:0] Fetch_Count,
    output logic [2:0]         State
);

    fetch_state_e       state_q, state_d;
    logic [COUNT_W-1:0] fetch_count_q, fetch_count_d;
    logic               halt_hit;
    fetch_ctrl_t        ctrl;
    logic               unused_ir_bits;

    assign halt_hit       = HALT_EN && (IROut[15:12] == HALT_OPCODE);
    assign unused_ir_bits = ^IROut[11:0];

    always_comb begin
        state_d       = state_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            IDLE: begin
                if (Run) state_d = FETCH_LO;
            end
            FETCH_LO: begin
                state_d = Flush ? FETCH_LO : FETCH_HI;
            end
            FETCH_HI: begin
                // A flushed high-byte fetch never completes, so it is not counted.
                if (Flush) begin
                    state_d = FETCH_LO;
                end else begin
                    state_d       = VALID;
                    fetch_count_d = fetch_count_q + COUNT_W'(1);
                end
            end
            VALID: begin
                if (Flush)            state_d = FETCH_LO;
                else if (halt_hit)    state_d = HALT;
                else if (Instr_Ready) state_d = Run ? FETCH_LO : IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Moore decode: control word depends on state_q only.
    always_comb begin
        ctrl = ctrl_word(1'b0, 1'b0);
        case (state_q)
            FETCH_LO: ctrl = ctrl_word(1'b1, 1'b0);
            FETCH_HI: ctrl = ctrl_word(1'b1, 1'b1);
            default:  ctrl = ctrl_word(1'b0, 1'b0);
        endcase
    end

    assign ARF_OutDSel = ctrl.out_d_sel;
    assign ARF_FunSel  = ctrl.arf_fun;
    assign ARF_RegSel  = ctrl.arf_reg_sel;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Enable   = ctrl.ir_en;
    assign IR_Funsel   = ctrl.ir_fun;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign Instr_Valid = (state_q == VALID);
    assign Halted      = (state_q == HALT);
    assign Busy        = (state_q == FETCH_LO) || (state_q == FETCH_HI);
    assign Fetch_Count = fetch_count_q;
    assign State       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer with a behavioural memory/PC/IR model standing in for ALU_System.
module tb_fetch_sequencer;

    logic        Clock, Reset, Run, Flush, Instr_Ready;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        pc_load;
    logic [7:0]  pc_ld_val;
    logic [7:0]  mem [0:255];

    logic [1:0] ARF_OutDSel, ARF_FunSel, IR_Funsel;
    logic [3:0] ARF_RegSel;
    logic       IR_LH, IR_Enable, Mem_WR, Mem_CS, Instr_Valid, Halted, Busy;
    logic [7:0] Fetch_Count;
    logic [2:0] State;

    logic [1:0] ARF_OutDSel2, ARF_FunSel2, IR_Funsel2;
    logic [3:0] ARF_RegSel2;
    logic       IR_LH2, IR_Enable2, Mem_WR2, Mem_CS2, Instr_Valid2, Halted2, Busy2;
    logic [1:0] Fetch_Count2;
    logic [2:0] State2;

    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.COUNT_W(8), .HALT_EN(1'b1), .HALT_OPCODE(4'hF)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Flush(Flush), .Instr_Ready(Instr_Ready),
        .IROut(ir), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .Instr_Valid(Instr_Valid), .Halted(Halted), .Busy(Busy),
        .Fetch_Count(Fetch_Count), .State(State)
    );

    // Narrow-counter copy driven by identical inputs; used only for wrap checks.
    fetch_sequencer #(.COUNT_W(2), .HALT_EN(1'b1), .HALT_OPCODE(4'hF)) dut2 (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Flush(Flush), .Instr_Ready(Instr_Ready),
        .IROut(ir), .ARF_OutDSel(ARF_OutDSel2), .ARF_FunSel(ARF_FunSel2), .ARF_RegSel(ARF_RegSel2),
        .IR_LH(IR_LH2), .IR_Enable(IR_Enable2), .IR_Funsel(IR_Funsel2), .Mem_WR(Mem_WR2),
        .Mem_CS(Mem_CS2), .Instr_Valid(Instr_Valid2), .Halted(Halted2), .Busy(Busy2),
        .Fetch_Count(Fetch_Count2), .State(State2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ALU_System stand-in: combinational memory read, IR byte load, PC increment or redirect.
    always @(posedge Clock) begin
        if (!Mem_CS && IR_Enable && IR_Funsel == 2'b10) begin
            if (IR_LH) ir[15:8] <= mem[pc];
            else       ir[7:0]  <= mem[pc];
        end
        if (pc_load)
            pc <= pc_ld_val;
        else if (!Mem_CS && ARF_OutDSel == 2'b00 && ARF_RegSel == 4'b0111 && ARF_FunSel == 2'b01)
            pc <= pc + 8'd1;
    end

    typedef struct {
        logic        pr;
        logic        run, flush, ready;
        logic [2:0]  st;
        logic        vld, busy, cs, lh;
        logic [7:0]  cnt;
        logic [7:0]  pcv;
        logic        chk_ir;
        logic [15:0] irv;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic pr, input logic run, input logic flush, input logic ready,
                                input logic [2:0] st, input logic vld, input logic busy, input logic cs,
                                input logic lh, input logic [7:0] cnt, input logic [7:0] pcv,
                                input logic chk_ir, input logic [15:0] irv);
        vec_t x;
        x.pr = pr; x.run = run; x.flush = flush; x.ready = ready;
        x.st = st; x.vld = vld; x.busy = busy; x.cs = cs; x.lh = lh;
        x.cnt = cnt; x.pcv = pcv; x.chk_ir = chk_ir; x.irv = irv;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] pcv);
        Reset = 1'b0; Run = 1'b0; Flush = 1'b0; Instr_Ready = 1'b0;
        pc_load = 1'b1; pc_ld_val = pcv;
        step();
        pc_load = 1'b0;
        Reset = 1'b1;
    endtask

    task automatic apply(input int i);
        vec_t x;
        x = vecs[i];
        if (x.pr) do_reset(8'h00);
        Run = x.run; Flush = x.flush; Instr_Ready = x.ready;
        step();
        check($sformatf("v%0d_state", i), 32'(State), 32'(x.st));
        check($sformatf("v%0d_valid", i), 32'(Instr_Valid), 32'(x.vld));
        check($sformatf("v%0d_busy", i), 32'(Busy), 32'(x.busy));
        check($sformatf("v%0d_cs", i), 32'(Mem_CS), 32'(x.cs));
        check($sformatf("v%0d_lh", i), 32'(IR_LH), 32'(x.lh));
        check($sformatf("v%0d_iren", i), 32'(IR_Enable), 32'(x.busy));
        check($sformatf("v%0d_regsel", i), 32'(ARF_RegSel), x.busy ? 32'h7 : 32'hF);
        check($sformatf("v%0d_count", i), 32'(Fetch_Count), 32'(x.cnt));
        check($sformatf("v%0d_count2", i), 32'(Fetch_Count2), 32'(x.cnt[1:0]));
        check($sformatf("v%0d_pc", i), 32'(pc), 32'(x.pcv));
        if (x.chk_ir) check($sformatf("v%0d_ir", i), 32'(ir), 32'(x.irv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0; Run = 1'b0; Flush = 1'b0; Instr_Ready = 1'b0;
        pc_load = 1'b0; pc_ld_val = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;
        mem[4] = 8'hBC; mem[5] = 8'h9A; mem[6] = 8'hF0; mem[7] = 8'hDE;
        mem[8'h10] = 8'hCD; mem[8'h11] = 8'hAB;
        mem[8'h20] = 8'h00; mem[8'h21] = 8'hF0;

        #12;
        check("rst_state", 32'(State), 32'd0);
        check("rst_valid", 32'(Instr_Valid), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_cs", 32'(Mem_CS), 32'd1);
        check("rst_wr", 32'(Mem_WR), 32'd0);
        check("rst_iren", 32'(IR_Enable), 32'd0);
        check("rst_lh", 32'(IR_LH), 32'd0);
        check("rst_irfun", 32'(IR_Funsel), 32'h2);
        check("rst_regsel", 32'(ARF_RegSel), 32'hF);
        check("rst_arffun", 32'(ARF_FunSel), 32'h1);
        check("rst_outdsel", 32'(ARF_OutDSel), 32'h0);
        check("rst_count", 32'(Fetch_Count), 32'd0);

        // Single fetch held by Ready=0.
        vecs[0]  = mk(1,1,0,0, 3'd1,0,1,0,0, 8'd0, 8'd0, 0,16'h0);
        vecs[1]  = mk(0,1,0,0, 3'd2,0,1,0,1, 8'd0, 8'd1, 0,16'h0);
        vecs[2]  = mk(0,1,0,0, 3'd3,1,0,1,0, 8'd1, 8'd2, 1,16'h1234);
        vecs[3]  = mk(0,1,0,0, 3'd3,1,0,1,0, 8'd1, 8'd2, 1,16'h1234);
        vecs[4]  = mk(0,1,0,0, 3'd3,1,0,1,0, 8'd1, 8'd2, 1,16'h1234);
        // Back-to-back stream, then Run dropped during FETCH_LO.
        vecs[5]  = mk(1,1,0,1, 3'd1,0,1,0,0, 8'd0, 8'd0, 0,16'h0);
        vecs[6]  = mk(0,1,0,1, 3'd2,0,1,0,1, 8'd0, 8'd1, 0,16'h0);
        vecs[7]  = mk(0,1,0,1, 3'd3,1,0,1,0, 8'd1, 8'd2, 1,16'h1234);
        vecs[8]  = mk(0,1,0,1, 3'd1,0,1,0,0, 8'd1, 8'd2, 0,16'h0);
        vecs[9]  = mk(0,1,0,1, 3'd2,0,1,0,1, 8'd1, 8'd3, 0,16'h0);
        vecs[10] = mk(0,1,0,1, 3'd3,1,0,1,0, 8'd2, 8'd4, 1,16'h5678);
        vecs[11] = mk(0,1,0,1, 3'd1,0,1,0,0, 8'd2, 8'd4, 0,16'h0);
        vecs[12] = mk(0,1,0,1, 3'd2,0,1,0,1, 8'd2, 8'd5, 0,16'h0);
        vecs[13] = mk(0,1,0,1, 3'd3,1,0,1,0, 8'd3, 8'd6, 1,16'h9ABC);
        vecs[14] = mk(0,1,0,1, 3'd1,0,1,0,0, 8'd3, 8'd6, 0,16'h0);
        vecs[15] = mk(0,1,0,1, 3'd2,0,1,0,1, 8'd3, 8'd7, 0,16'h0);
        vecs[16] = mk(0,1,0,1, 3'd3,1,0,1,0, 8'd4, 8'd8, 1,16'hDEF0);
        vecs[17] = mk(0,1,0,0, 3'd3,1,0,1,0, 8'd4, 8'd8, 1,16'hDEF0);
        vecs[18] = mk(0,1,0,1, 3'd1,0,1,0,0, 8'd4, 8'd8, 0,16'h0);
        vecs[19] = mk(0,0,0,0, 3'd2,0,1,0,1, 8'd4, 8'd9, 0,16'h0);
        vecs[20] = mk(0,0,0,0, 3'd3,1,0,1,0, 8'd5, 8'd10,1,16'h0000);
        vecs[21] = mk(0,0,0,1, 3'd0,0,0,1,0, 8'd5, 8'd10,0,16'h0);
        vecs[22] = mk(0,0,0,0, 3'd0,0,0,1,0, 8'd5, 8'd10,0,16'h0);

        for (int i = 0; i < NV; i++) apply(i);

        // Flush ignored in IDLE, honoured in FETCH_HI and VALID.
        do_reset(8'h00);
        Flush = 1'b1;
        step();
        check("flush_idle_state", 32'(State), 32'd0);
        Flush = 1'b0; Run = 1'b1;
        step();
        check("fl_lo_state", 32'(State), 32'd1);
        step();
        check("fl_hi_state", 32'(State), 32'd2);
        Flush = 1'b1; pc_load = 1'b1; pc_ld_val = 8'h10;
        step();
        Flush = 1'b0; pc_load = 1'b0;
        check("fl_hi_next", 32'(State), 32'd1);
        check("fl_hi_count", 32'(Fetch_Count), 32'd0);
        check("fl_hi_pc", 32'(pc), 32'h10);
        step();
        step();
        check("fl_refetch_state", 32'(State), 32'd3);
        check("fl_refetch_ir", 32'(ir), 32'hABCD);
        check("fl_refetch_count", 32'(Fetch_Count), 32'd1);
        check("fl_refetch_pc", 32'(pc), 32'h12);
        Flush = 1'b1; pc_load = 1'b1; pc_ld_val = 8'h10;
        step();
        Flush = 1'b0; pc_load = 1'b0;
        check("fl_valid_next", 32'(State), 32'd1);
        check("fl_valid_count", 32'(Fetch_Count), 32'd1);
        step();
        step();
        check("fl_valid_refetch_ir", 32'(ir), 32'hABCD);
        check("fl_valid_refetch_count", 32'(Fetch_Count), 32'd2);

        // HALT opcode: flush wins over halt once, then halt freezes everything.
        do_reset(8'h20);
        Run = 1'b1;
        step(); step(); step();
        check("halt_valid", 32'(Instr_Valid), 32'd1);
        check("halt_ir", 32'(ir), 32'hF000);
        Flush = 1'b1; pc_load = 1'b1; pc_ld_val = 8'h20;
        step();
        Flush = 1'b0; pc_load = 1'b0;
        check("halt_flush_prio", 32'(State), 32'd1);
        step(); step();
        check("halt_refetch_state", 32'(State), 32'd3);
        Instr_Ready = 1'b1;
        step();
        check("halt_state", 32'(State), 32'd4);
        check("halt_halted", 32'(Halted), 32'd1);
        check("halt_valid_off", 32'(Instr_Valid), 32'd0);
        check("halt_cs", 32'(Mem_CS), 32'd1);
        check("halt_busy", 32'(Busy), 32'd0);
        check("halt_count", 32'(Fetch_Count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            Run = 1'b1; Instr_Ready = 1'b1; Flush = i[0];
            step();
            check($sformatf("halt_hold%0d_state", i), 32'(State), 32'd4);
            check($sformatf("halt_hold%0d_pc", i), 32'(pc), 32'h22);
        end
        Flush = 1'b0;
        #3 Reset = 1'b0;
        #1;
        check("halt_rst_state", 32'(State), 32'd0);
        check("halt_rst_halted", 32'(Halted), 32'd0);
        check("halt_rst_count", 32'(Fetch_Count), 32'd0);
        check("halt_rst_count2", 32'(Fetch_Count2), 32'd0);

        // Asynchronous reset mid-cycle while in FETCH_LO.
        do_reset(8'h00);
        Run = 1'b1;
        step(); step(); step();
        check("arst_pre_count", 32'(Fetch_Count), 32'd1);
        Instr_Ready = 1'b1;
        step();
        check("arst_pre_state", 32'(State), 32'd1);
        #3 Reset = 1'b0;
        #1;
        check("arst_state", 32'(State), 32'd0);
        check("arst_cs", 32'(Mem_CS), 32'd1);
        check("arst_iren", 32'(IR_Enable), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_regsel", 32'(ARF_RegSel), 32'hF);
        check("arst_count", 32'(Fetch_Count), 32'd0);
        Run = 1'b0; Instr_Ready = 1'b0;
        Reset = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
